// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types and bit-order helpers for the OPB register bank.
// OPB numbers bits [0:31] MSB-first; user logic sees [31:0].
package opb_reg_bank_pkg;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} bus_state_e;

  localparam int COMMIT_BIT = 0;

  // OPB_BE[lane] covers user bits [lane_lsb(lane) +: 8]
  function automatic int lane_lsb(input int lane);
    return 24 - 8 * lane;
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [0:3] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) m[lane_lsb(k) +: 8] = {8{be[k]}};
    return m;
  endfunction

  function automatic logic [31:0] opb_to_user(input logic [0:31] d);
    logic [31:0] u;
    for (int i = 0; i < 32; i++) u[31-i] = d[i];
    return u;
  endfunction

  function automatic logic [0:31] user_to_opb(input logic [31:0] u);
    logic [0:31] d;
    for (int i = 0; i < 32; i++) d[i] = u[31-i];
    return d;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_decode.sv
// OPB slave front end: address window check, word index and the
// two-state IDLE/ACK handshake that produces a single-cycle xferAck.
module opb_slave_decode
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        select,
  output logic        go,
  output logic [29:0] word_idx,
  output logic        xfer_ack
);

  bus_state_e  state;
  logic [31:0] offset;
  logic        in_range;
  logic        unused_ok;

  // Addresses below the base wrap to large offsets and fall outside the window
  assign offset    = addr - C_BASEADDR;
  assign in_range  = offset <= (C_HIGHADDR - C_BASEADDR);
  assign word_idx  = offset[31:2];
  assign go        = (state == IDLE) && select && in_range;
  assign xfer_ack  = (state == ACK);
  assign unused_ok = ^offset[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (go) state <= ACK;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB bank of C_NUM_REGS read-back registers driving Simulink user logic.
// Define OPB_REG_BANK_ATOMIC_EN to stage writes in shadows applied by COMMIT.
module opb_register_bank_ppc2simulink
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_NUM_REGS   = 8,
  parameter int          C_REG_WIDTH  = 32,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                                OPB_Clk,
  input  logic                                OPB_Rst_n,
  input  logic [0:31]                         OPB_ABus,
  input  logic [0:3]                          OPB_BE,
  input  logic [0:31]                         OPB_DBus,
  input  logic                                OPB_RNW,
  input  logic                                OPB_select,
  input  logic                                OPB_seqAddr,
  output logic [0:31]                         Sl_DBus,
  output logic                                Sl_xferAck,
  output logic                                Sl_errAck,
  output logic                                Sl_retry,
  output logic                                Sl_toutSup,
  output logic [C_NUM_REGS*C_REG_WIDTH-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]               user_update
);

  localparam int W = C_REG_WIDTH;
  localparam int N = C_NUM_REGS;

  logic [31:0]   addr_u, wdata_u, wmask, rd_mux, rd_q, commit_word;
  logic [29:0]   word_idx;
  logic          go, wr_go, rd_go, commit_sel;
  logic [N-1:0]  wr_hit, upd_q;
  logic [W-1:0]  shadow [N];
  logic [W-1:0]  out_q  [N];
  logic          unused_ok;

  assign addr_u     = opb_to_user(OPB_ABus);
  assign wdata_u    = opb_to_user(OPB_DBus);
  assign wmask      = be_to_mask(OPB_BE);
  assign wr_go      = go & ~OPB_RNW;
  assign rd_go      = go & OPB_RNW;
  assign commit_sel = (word_idx == 30'(N));
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign unused_ok  = ^{OPB_seqAddr, wdata_u, wmask, C_OPB_AWIDTH == 32, C_OPB_DWIDTH == 32};

  opb_slave_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_decode (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .addr     (addr_u),
    .select   (OPB_select),
    .go       (go),
    .word_idx (word_idx),
    .xfer_ack (Sl_xferAck)
  );

  // An all-zero byte enable counts as no write: no strobe, no dirty flag
  always_comb begin
    for (int i = 0; i < N; i++) wr_hit[i] = wr_go && (word_idx == 30'(i)) && (|OPB_BE);
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (wr_hit[i])
          shadow[i] <= (shadow[i] & ~wmask[W-1:0]) | (wdata_u[W-1:0] & wmask[W-1:0]);
    end
  end

`ifdef OPB_REG_BANK_ATOMIC_EN
  logic [N-1:0] dirty;
  logic         commit_go;

  assign commit_go = wr_go && commit_sel && wmask[COMMIT_BIT] && wdata_u[COMMIT_BIT];

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      dirty <= '0;
      upd_q <= '0;
      for (int i = 0; i < N; i++) out_q[i] <= '0;
    end else begin
      upd_q <= '0;
      if (commit_go) begin
        for (int i = 0; i < N; i++)
          if (dirty[i]) out_q[i] <= shadow[i];
        upd_q <= dirty;
        dirty <= '0;
      end else begin
        dirty <= dirty | wr_hit;
      end
    end
  end

  // Dirty mask above bit 0; registers beyond 31 have no room and are dropped
  always_comb begin
    commit_word    = '0;
    commit_word[0] = |dirty;
    for (int i = 0; i < N && i < 31; i++) commit_word[i+1] = dirty[i];
  end
`else
  assign out_q       = shadow;
  assign commit_word = '0;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) upd_q <= '0;
    else            upd_q <= wr_hit;
  end
`endif

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N; i++)
      if (word_idx == 30'(i)) rd_mux = 32'(shadow[i]);
    if (commit_sel) rd_mux = commit_word;
  end

  // Read data is loaded only for the ACK cycle so the bus sees zero otherwise
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) rd_q <= '0;
    else            rd_q <= rd_go ? rd_mux : '0;
  end

  assign Sl_DBus     = user_to_opb(rd_q);
  assign user_update = upd_q;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign user_data_out[g*W +: W] = out_q[g];
  end

endmodule
